// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register-index width and hazard FSM
// state encodings used by the hazard controller and its load-use detector.
package riscv_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_REDIR_PEND = 2'd2
  } hz_state_e;

  // True when an enabled source operand names the given destination register.
  function automatic logic src_hits(input reg_idx_t src, input logic en, input reg_idx_t rd);
    return en && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the EX instruction is a load writing a
// non-zero register that the ID instruction actually reads.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_ren,
  input  logic                 ex_reg_wen,
  output logic                 load_use
);

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  always_comb begin
    load_use = ex_mem_ren && ex_reg_wen && (ex_rd != '0) &&
               (src_hits(id_rs1, id_use_rs1, ex_rd) || src_hits(id_rs2, id_use_rs2, ex_rd));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush generation for the
// PC, IF/ID, ID/EX and EX/MEM registers, plus a small FSM that remembers a
// redirect arriving during a data-cache stall and keeps squashing fetch while
// the instruction cache catches up after a redirect.
// Optional performance counters (stall_cnt, flush_cnt) are built only when
// the macro HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_ren,
  input  logic                 ex_reg_wen,
  input  logic                 ex_redirect,
  input  logic                 icache_stall,
  input  logic                 dcache_stall,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_stall,
  output logic                 exmem_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [1:0]           state_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  hz_state_e state_q;
  logic      pend_q;
  logic      load_use;
  logic      redir_now;

  hazard_detect u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_mem_ren (ex_mem_ren),
    .ex_reg_wen (ex_reg_wen),
    .load_use   (load_use)
  );

  assign redir_now = ex_redirect || pend_q;
  assign state_o   = state_q;

  // Stall/flush decode in priority order: reset, dcache, redirect, load-use, icache.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dcache_stall) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else if (redir_now) begin
      // The fetch PC must not advance past the redirect target while icache is busy.
      pc_stall   = icache_stall;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state_q == ST_REDIR_PEND) && icache_stall) begin
      // ID only ever holds a bubble here, so load-use cannot apply.
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (icache_stall) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  // FSM and pending-redirect flag; the unused encoding falls through to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
    end else if (dcache_stall) begin
      state_q <= ST_MEM_WAIT;
      pend_q  <= pend_q || ex_redirect;
    end else if (redir_now) begin
      state_q <= icache_stall ? ST_REDIR_PEND : ST_RUN;
      pend_q  <= 1'b0;
    end else if ((state_q == ST_REDIR_PEND) && icache_stall) begin
      state_q <= ST_REDIR_PEND;
    end else begin
      state_q <= ST_RUN;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  // Saturating cycle counters; idex_flush during reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, pc_stall);
      flush_cnt <= sat_inc(flush_cnt, idex_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with fixed
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_ren, ex_reg_wen;
  logic       ex_redirect, icache_stall, dcache_stall;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
  logic [1:0] state_o;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: 0 running, 1 waiting on data memory, 2 waiting on fetch after redirect.
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_ren   (ex_mem_ren),
    .ex_reg_wen   (ex_reg_wen),
    .ex_redirect  (ex_redirect),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exmem_stall  (exmem_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state_o      (state_o)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Observed outputs packed as {pc, ifid, idex, exmem stalls, ifid, idex flushes}.
  function automatic logic [5:0] outs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
  endfunction

  // Expected outputs from the priority rules applied to current inputs and model state.
  function automatic logic [5:0] model_out();
    logic lu;
    lu = ex_mem_ren && ex_reg_wen && (ex_rd != 0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    if (rst)                          return 6'b0000_11;
    if (dcache_stall)                 return 6'b1111_00;
    if (ex_redirect || m_pend)        return {icache_stall, 3'b000, 2'b11};
    if (m_mode == 2 && icache_stall)  return 6'b1000_10;
    if (lu)                           return 6'b1100_01;
    if (icache_stall)                 return 6'b1000_10;
    return 6'b0000_00;
  endfunction

  task automatic model_step();
    logic [5:0] o;
    o = model_out();
    if (rst) begin
      m_mode = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (o[5] && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (o[0] && m_flush != 32'hFFFF_FFFF) m_flush++;
      if (dcache_stall) begin
        m_mode = 1;
        m_pend = m_pend || ex_redirect;
      end else if (ex_redirect || m_pend) begin
        m_mode = icache_stall ? 2 : 0;
        m_pend = 0;
      end else if (!(m_mode == 2 && icache_stall)) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_ren = 0; ex_reg_wen = 0; ex_redirect = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      {id_rs1, id_rs2, ex_rd} = 15'($urandom);
      {id_use_rs1, id_use_rs2, ex_mem_ren, ex_reg_wen, ex_redirect, icache_stall, dcache_stall} = 7'($urandom);
      rst = 1;
      #1;
      total++;
      if (outs() !== 6'b0000_11) begin
        bad++; $display("FAIL reset_outputs got=%b exp=%b", outs(), 6'b0000_11);
      end
      tick();
      total++;
      if (state_o !== 2'd0) begin
        bad++; $display("FAIL reset_state got=%0d exp=0", state_o);
      end
    end
`ifdef HAZARD_CTRL_PERF_EN
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
`endif
    idle();
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 9; id_use_rs1 = 1;
    #1;
    total++;
    if (outs() !== 6'b1100_01) begin
      bad++; $display("FAIL load_use_rs2 got=%b exp=%b", outs(), 6'b1100_01);
    end
    tick();
    ex_mem_ren = 0;
    #1;
    total++;
    if (outs() !== 6'b0000_00) begin
      bad++; $display("FAIL load_use_one_cycle got=%b exp=%b", outs(), 6'b0000_00);
    end
    ex_mem_ren = 1; ex_rd = 0; id_rs2 = 0; id_rs1 = 0;
    #1;
    total++;
    if (outs() !== 6'b0000_00) begin
      bad++; $display("FAIL load_use_x0 got=%b exp=%b", outs(), 6'b0000_00);
    end
    ex_rd = 12; id_rs1 = 12; id_use_rs1 = 0; id_rs2 = 3;
    #1;
    total++;
    if (outs() !== 6'b0000_00) begin
      bad++; $display("FAIL load_use_unused_src got=%b exp=%b", outs(), 6'b0000_00);
    end
    id_use_rs1 = 1; icache_stall = 1;
    #1;
    total++;
    if (outs() !== 6'b1100_01) begin
      bad++; $display("FAIL load_use_over_icache got=%b exp=%b", outs(), 6'b1100_01);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_redirect();
    idle();
    ex_redirect = 1;
    ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    #1;
    total++;
    if (outs() !== 6'b0000_11) begin
      bad++; $display("FAIL redirect_alone got=%b exp=%b", outs(), 6'b0000_11);
    end
    tick();
    total++;
    if (state_o !== 2'd0) begin
      bad++; $display("FAIL redirect_state got=%0d exp=0", state_o);
    end
    idle();
    icache_stall = 1;
    #1;
    total++;
    if (outs() !== 6'b1000_10) begin
      bad++; $display("FAIL icache_only got=%b exp=%b", outs(), 6'b1000_10);
    end
    tick();
    idle();
  endtask

  task automatic test_redirect_dstall();
    idle();
    ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      dcache_stall = 1;
      #1;
      total++;
      if (outs() !== 6'b1111_00) begin
        bad++; $display("FAIL dstall_cycle%0d got=%b exp=%b", i, outs(), 6'b1111_00);
      end
      tick();
      total++;
      if (state_o !== 2'd1) begin
        bad++; $display("FAIL dstall_state%0d got=%0d exp=1", i, state_o);
      end
      ex_redirect = 0;
    end
    dcache_stall = 0;
    #1;
    total++;
    if (outs() !== 6'b0000_11) begin
      bad++; $display("FAIL pending_redirect_applied got=%b exp=%b", outs(), 6'b0000_11);
    end
    tick();
    #1;
    total++;
    if (state_o !== 2'd0 || outs() !== 6'b0000_00) begin
      bad++; $display("FAIL pending_cleared got=%0d/%b exp=0/000000", state_o, outs());
    end
  endtask

  task automatic test_redirect_istall();
    idle();
    ex_redirect = 1; icache_stall = 1;
    #1;
    total++;
    if (outs() !== 6'b1000_11) begin
      bad++; $display("FAIL istall_redirect got=%b exp=%b", outs(), 6'b1000_11);
    end
    tick();
    ex_redirect = 0;
    total++;
    if (state_o !== 2'd2) begin
      bad++; $display("FAIL istall_state1 got=%0d exp=2", state_o);
    end
    ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 6; id_rs1 = 6; id_use_rs1 = 1;
    #1;
    total++;
    if (outs() !== 6'b1000_10) begin
      bad++; $display("FAIL istall_pend got=%b exp=%b", outs(), 6'b1000_10);
    end
    tick();
    total++;
    if (state_o !== 2'd2) begin
      bad++; $display("FAIL istall_state2 got=%0d exp=2", state_o);
    end
    idle();
    #1;
    total++;
    if (outs() !== 6'b0000_00) begin
      bad++; $display("FAIL istall_release got=%b exp=%b", outs(), 6'b0000_00);
    end
    tick();
    total++;
    if (state_o !== 2'd0) begin
      bad++; $display("FAIL istall_back_to_run got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_reset_in_wait();
    idle();
    dcache_stall = 1; ex_redirect = 1;
    tick();
    total++;
    if (state_o !== 2'd1) begin
      bad++; $display("FAIL wait_before_reset got=%0d exp=1", state_o);
    end
    idle();
    rst = 1;
    #1;
    total++;
    if (outs() !== 6'b0000_11) begin
      bad++; $display("FAIL reset_in_wait_out got=%b exp=%b", outs(), 6'b0000_11);
    end
    tick();
    total++;
    if (state_o !== 2'd0) begin
      bad++; $display("FAIL reset_in_wait_state got=%0d exp=0", state_o);
    end
    rst = 0;
    #1;
    total++;
    if (outs() !== 6'b0000_00) begin
      bad++; $display("FAIL pending_discarded got=%b exp=%b", outs(), 6'b0000_00);
    end
`ifdef HAZARD_CTRL_PERF_EN
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    end
`endif
    tick();
  endtask

`ifdef HAZARD_CTRL_PERF_EN
  task automatic test_perf();
    idle();
    rst = 1;
    tick();
    rst = 0;
    ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    repeat (10) tick();
    idle();
    total++;
    if (stall_cnt !== 32'd10 || flush_cnt !== 32'd10) begin
      bad++; $display("FAIL perf_load_use got=%0d/%0d exp=10/10", stall_cnt, flush_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(99, 0) < 4);
      dcache_stall = ($urandom_range(99, 0) < 25);
      icache_stall = ($urandom_range(99, 0) < 35);
      ex_redirect  = ($urandom_range(99, 0) < 20);
      ex_mem_ren   = ($urandom_range(99, 0) < 60);
      ex_reg_wen   = ($urandom_range(99, 0) < 80);
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_rd        = 5'($urandom_range(3, 0));
      id_rs1       = 5'($urandom_range(3, 0));
      id_rs2       = 5'($urandom_range(3, 0));
      #1;
      total++;
      if (outs() !== model_out()) begin
        bad++; $display("FAIL rand_out[%0d] got=%b exp=%b", i, outs(), model_out());
      end
      tick();
      total++;
      if (state_o !== 2'(m_mode)) begin
        bad++; $display("FAIL rand_state[%0d] got=%0d exp=%0d", i, state_o, m_mode);
      end
`ifdef HAZARD_CTRL_PERF_EN
      total++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    idle();
  endtask

  initial begin
    m_mode = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_dstall();
    test_redirect_istall();
    test_reset_in_wait();
`ifdef HAZARD_CTRL_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-004 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-005 SHALL have ports ex_rd  in  5, ex_mem_ren  in  1, ex_reg_wen  in  1  destination, load flag and writeback flag of the instruction in EX.
REQ-006 SHALL have port ex_redirect  in  1  EX resolved a taken branch, jal or jalr this cycle.
REQ-007 SHALL have ports icache_stall, dcache_stall  in  1 each  memory not ready.
REQ-008 SHALL have outputs pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the named register.
REQ-009 SHALL have outputs ifid_flush, idex_flush  out  1 each  load a bubble into the named register.
REQ-010 SHALL have output state_o  out  2  current FSM state; perf outputs per REQ-027.

Function
REQ-011 SHALL drive all stall and flush outputs combinationally from inputs and state, with zero-cycle latency.
REQ-012 SHALL implement FSM states RUN=0, MEM_WAIT=1, REDIR_PEND=2; encoding 3 is unreachable and SHALL return to RUN.
REQ-013 SHALL, whenever dcache_stall=1, assert all four stalls and deassert both flushes, regardless of other inputs.
REQ-014 SHALL enter MEM_WAIT when dcache_stall=1 and return to RUN on the first cycle dcache_stall=0, unless a redirect is pending (REQ-017).
REQ-015 SHALL detect load-use hazard = ex_mem_ren & ex_reg_wen & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-016 SHALL, on load-use hazard (dcache_stall=0, ex_redirect=0), assert pc_stall, ifid_stall, idex_flush for exactly that cycle; idex_stall=0, exmem_stall=0.
REQ-017 SHALL, on ex_redirect=1 with dcache_stall=1, latch a pending redirect and enter MEM_WAIT; redirect is applied on the first cycle dcache_stall=0.
REQ-018 SHALL, on applied redirect, assert idex_flush and ifid_flush, deassert idex_stall; load-use hazard SHALL be ignored that cycle.
REQ-019 SHALL, if icache_stall=1 when a redirect is applied, assert pc_stall and enter REDIR_PEND, asserting ifid_flush each cycle until icache_stall=0, then return to RUN.
REQ-020 SHALL, with icache_stall=1 and no other event, assert pc_stall and ifid_flush (bubble into ID); idex/exmem not stalled.
REQ-021 SHALL give priority dcache_stall > redirect (new or pending) > load-use > icache_stall.
REQ-022 SHALL, on a new ex_redirect in REDIR_PEND, remain in REDIR_PEND (newest redirect wins; no counting).

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state to RUN and clear the pending-redirect flag, discarding any in-flight wait.
REQ-024 SHALL, while rst=1, drive all stalls 0 and ifid_flush=idex_flush=1.
REQ-025 SHALL clear perf counters (REQ-027) on reset.

Configuration
REQ-026 SHALL compile performance counters only when macro HAZARD_CTRL_PERF_EN is defined.
REQ-027 SHALL, with HAZARD_CTRL_PERF_EN, provide outputs stall_cnt (32, cycles with pc_stall=1) and flush_cnt (32, cycles with idex_flush=1 outside reset), saturating at 0xFFFFFFFF; without it these ports SHALL not exist.

Structure
REQ-028 SHALL take state encodings and the 5-bit register-index width from shared package riscv_pkg.
REQ-029 SHALL optionally place the REQ-015 comparator in sub-module hazard_detect; FSM and counters stay in hazard_ctrl.

Verification
REQ-030 SHALL check: ex_mem_ren=1, ex_reg_wen=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle; ex_rd=0 -> no stall.
REQ-031 SHALL check: ex_redirect=1 alone -> ifid_flush=idex_flush=1, idex_stall=0, state stays RUN.
REQ-032 SHALL check: ex_redirect=1 with dcache_stall=1 for 3 cycles -> all stalls 1, flushes 0, state_o=1; 4th cycle both flushes 1.
REQ-033 SHALL check: redirect with icache_stall=1 for 2 cycles -> state_o=2, ifid_flush=1 and pc_stall=1 both cycles, RUN after icache_stall=0.
REQ-034 SHALL check: rst=1 asserted in MEM_WAIT -> next cycle state_o=0, pending redirect gone, stall_cnt=0.
REQ-035 SHALL check (PERF_EN): 10 load-use cycles -> stall_cnt=10, flush_cnt=10.
